// File: rtl/fetch_prefetch_queue_if.sv
// fetch_prefetch_queue_if: redirect, instruction-memory and decode-side signals of the fetch stage
interface fetch_prefetch_queue_if #(parameter int N = 16);
  logic redirect;
  logic [N-1:0] redirect_pc;
  logic deq;
  logic mem_rd;
  logic [N-1:0] mem_addr;
  logic mem_done;
  logic [N-1:0] mem_data;
  logic mem_err;
  logic instr_valid;
  logic [N-1:0] instr;
  logic [N-1:0] pcplus;
  logic instr_halt;
  logic fetch_stall;
  logic err;
  modport master (
    output redirect, redirect_pc, deq, mem_done, mem_data, mem_err,
    input mem_rd, mem_addr, instr_valid, instr, pcplus, instr_halt, fetch_stall, err
  );
  modport slave (
    input redirect, redirect_pc, deq, mem_done, mem_data, mem_err,
    output mem_rd, mem_addr, instr_valid, instr, pcplus, instr_halt, fetch_stall, err
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: single-outstanding sequential prefetch into a FWFT queue feeding IF/ID
module fetch_prefetch_queue #(
  parameter int N = 16,
  parameter int DEPTH = 4,
  parameter int INC = 2,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  fetch_prefetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD, STOP} state_t;
  typedef struct packed {
    logic [N-1:0] instr;
    logic [N-1:0] pcplus;
    logic halt;
  } ent_t;
  state_t state_q, state_d;
  logic [N-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW:0] count_q, count_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic err_q, err_d;
  ent_t ent_q [DEPTH];
  ent_t ent_d, head;
  logic issue, accept, enq, deq_ok;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // a redirect racing a response drops it; without a response the read is left to be discarded
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = issue ? WAIT : IDLE;
      WAIT: state_d = bus.mem_done
        ? ((bus.redirect || !(bus.mem_err || bus.mem_data == '0)) ? IDLE : STOP)
        : (bus.redirect ? DISCARD : WAIT);
      DISCARD: state_d = bus.mem_done ? IDLE : DISCARD;
      default: state_d = bus.redirect ? IDLE : STOP;
    endcase
  end
  always_comb begin
    issue = !rst && state_q == IDLE && count_q < FULL && !bus.redirect;
    bus.mem_rd = issue;
    bus.mem_addr = issue ? fetch_pc_q : '0;
    bus.fetch_stall = !rst && count_q == '0 && state_q != STOP;
  end
  always_comb begin
    accept = state_q == WAIT && bus.mem_done && !bus.redirect;
    enq = accept && !bus.mem_err;
    deq_ok = bus.deq && count_q != '0;
    ent_d = {bus.mem_data, fetch_pc_q + N'(INC), bus.mem_data == '0};
    fetch_pc_d = bus.redirect ? bus.redirect_pc : enq ? ent_d.pcplus : fetch_pc_q;
    count_d = bus.redirect ? '0 : count_q + (AW+1)'(enq) - (AW+1)'(deq_ok);
    wr_d = bus.redirect ? '0 : wr_q + AW'(enq);
    rd_d = bus.redirect ? '0 : rd_q + AW'(deq_ok);
    err_d = err_q | (accept && bus.mem_err);
    head = count_q != '0 ? ent_q[rd_q] : '0;
    bus.instr_valid = count_q != '0;
    bus.instr = head.instr;
    bus.pcplus = head.pcplus;
    bus.instr_halt = head.halt;
    bus.err = err_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      count_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q <= count_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      err_q <= err_d;
      if (enq) ent_q[wr_q] <= ent_d;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: randomized fetch-stage bench checked against a queue-level model
module tb_fetch_prefetch_queue;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic [15:0] i;
    logic [15:0] p;
    logic h;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fetch_prefetch_queue_if #(.N(16)) bus ();
  fetch_prefetch_queue #(.N(16), .DEPTH(DEPTH), .INC(2), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  int tests = 0, fails = 0, cycn = 0;
  logic [15:0] mem_img [256];
  ent_t q[$];
  logic [15:0] fpc = 16'h0;
  logic busy = 1'b0, stale = 1'b0, stopped = 1'b0, merr = 1'b0, e_rd = 1'b0;
  logic [52:0] exp_v, act_v;
  logic [15:0] reads[$];
  logic [15:0] pend_addr = 16'h0;
  int pend_cnt = 0, lat_min = 1, lat_max = 1;
  logic halt_en = 1'b0, err_en = 1'b0;
  logic [15:0] halt_addr = 16'h0, err_addr = 16'h0;
  assign act_v = {bus.mem_rd, bus.mem_addr, bus.instr_valid, bus.instr, bus.pcplus,
                  bus.instr_halt, bus.fetch_stall, bus.err};
  function automatic logic [15:0] word(logic [15:0] a);
    return (halt_en && a == halt_addr) ? 16'h0 : mem_img[a[8:1]];
  endfunction
  task automatic predict();
    ent_t h;
    #1;
    h = q.size() != 0 ? q[0] : '0;
    e_rd = !rst && !busy && !stopped && q.size() < DEPTH && !bus.redirect;
    exp_v = rst ? '0 : {e_rd, e_rd ? fpc : 16'h0, q.size() != 0, h.i, h.p, h.h,
                        q.size() == 0 && !stopped, merr};
  endtask
  task automatic tick();
    ent_t e;
    if (rst) begin
      q.delete(); fpc = 16'h0; busy = 0; stale = 0; stopped = 0; merr = 0;
    end else if (bus.redirect) begin
      q.delete(); fpc = bus.redirect_pc; stopped = 0;
      if (busy && bus.mem_done) begin busy = 0; stale = 0; end
      else if (busy) stale = 1;
    end else begin
      if (bus.deq && q.size() != 0) void'(q.pop_front());
      if (busy && bus.mem_done) begin
        busy = 0;
        if (stale) stale = 0;
        else if (bus.mem_err) begin merr = 1; stopped = 1; end
        else begin
          e = {bus.mem_data, fpc + 16'd2, bus.mem_data == 16'h0};
          q.push_back(e);
          fpc = fpc + 16'd2;
          stopped = bus.mem_data == 16'h0;
        end
      end
      if (e_rd) busy = 1;
    end
    if (bus.mem_rd) begin
      pend_addr = bus.mem_addr;
      pend_cnt = $urandom_range(lat_max, lat_min);
      reads.push_back(bus.mem_addr);
    end
    @(posedge clk);
    #1;
    bus.mem_done = 0; bus.mem_err = 0; bus.mem_data = 16'h0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        bus.mem_done = 1;
        bus.mem_data = word(pend_addr);
        bus.mem_err = err_en && pend_addr == err_addr;
      end
    end
    cycn++;
  endtask
  task automatic do_reset();
    rst = 1; pend_cnt = 0; halt_en = 0; err_en = 0; lat_min = 1; lat_max = 1;
    bus.redirect = 0; bus.redirect_pc = 16'h0; bus.deq = 0;
    bus.mem_done = 0; bus.mem_data = 16'h0; bus.mem_err = 0;
    predict(); tick(); predict(); tick();
    rst = 0;
    reads.delete();
  endtask
  task automatic test_reset();
    rst = 1;
    bus.redirect = 0; bus.redirect_pc = 16'h0; bus.deq = 0;
    bus.mem_done = 0; bus.mem_data = 16'h0; bus.mem_err = 0;
    repeat (2) begin
      predict();
      tests++;
      if (act_v !== 53'h0) begin fails++; $display("FAIL reset_outputs got=%h exp=0", act_v); end
      tick();
    end
    rst = 0;
    predict();
    tests++;
    if (act_v !== exp_v) begin fails++; $display("FAIL reset_release got=%h exp=%h", act_v, exp_v); end
    tests++;
    if ({bus.mem_rd, bus.mem_addr, bus.fetch_stall} !== {1'b1, 16'h0, 1'b1}) begin
      fails++; $display("FAIL reset_first_req got=%b/%h/%b exp=1/0000/1", bus.mem_rd, bus.mem_addr, bus.fetch_stall);
    end
    tick();
  endtask
  task automatic test_stream();
    do_reset();
    bus.deq = 1;
    repeat (20) begin
      predict(); tests++;
      if (act_v !== exp_v) begin fails++; $display("FAIL stream cyc=%0d got=%h exp=%h", cycn, act_v, exp_v); end
      tick();
    end
    tests++;
    if (reads.size() != 10) begin fails++; $display("FAIL stream_rate got=%0d exp=10", reads.size()); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (reads[k] !== 16'(2 * k)) begin fails++; $display("FAIL stream_addr%0d got=%h exp=%h", k, reads[k], 16'(2 * k)); end
    end
    bus.deq = 0;
  endtask
  task automatic test_fill();
    do_reset();
    repeat (12) begin
      predict(); tests++;
      if (act_v !== exp_v) begin fails++; $display("FAIL fill cyc=%0d got=%h exp=%h", cycn, act_v, exp_v); end
      tick();
    end
    tests++;
    if (reads.size() != 4 || reads[3] !== 16'h6 || bus.instr_valid !== 1'b1) begin
      fails++; $display("FAIL fill_full got=%0d/%h/%b exp=4/0006/1", reads.size(), reads[3], bus.instr_valid);
    end
    bus.mem_done = 1; bus.mem_data = 16'hBEEF;
    predict(); tests++;
    if (act_v !== exp_v) begin fails++; $display("FAIL fill_spurious got=%h exp=%h", act_v, exp_v); end
    tick();
    bus.deq = 1;
    predict(); tests++;
    if (act_v !== exp_v) begin fails++; $display("FAIL fill_deq got=%h exp=%h", act_v, exp_v); end
    tick();
    bus.deq = 0;
    repeat (4) begin
      predict(); tests++;
      if (act_v !== exp_v) begin fails++; $display("FAIL fill_refill cyc=%0d got=%h exp=%h", cycn, act_v, exp_v); end
      tick();
    end
    tests++;
    if (reads.size() != 5 || reads[4] !== 16'h8) begin
      fails++; $display("FAIL fill_one_more got=%0d/%h exp=5/0008", reads.size(), reads[4]);
    end
  endtask
  task automatic test_redirect_wait();
    do_reset();
    lat_min = 4; lat_max = 4;
    predict(); tests++;
    if (act_v !== exp_v) begin fails++; $display("FAIL redir_issue got=%h exp=%h", act_v, exp_v); end
    tick();
    bus.redirect = 1; bus.redirect_pc = 16'h0100;
    predict(); tests++;
    if (act_v !== exp_v) begin fails++; $display("FAIL redir_cycle got=%h exp=%h", act_v, exp_v); end
    tick();
    bus.redirect = 0;
    repeat (12) begin
      predict(); tests++;
      if (act_v !== exp_v) begin fails++; $display("FAIL redir cyc=%0d got=%h exp=%h", cycn, act_v, exp_v); end
      tick();
    end
    tests++;
    if (reads.size() < 2 || reads[1] !== 16'h0100 || bus.pcplus !== 16'h0102 || bus.instr_valid !== 1'b1) begin
      fails++; $display("FAIL redir_target got=%h/%h exp=0100/0102", reads[1], bus.pcplus);
    end
  endtask
  task automatic test_collision();
    do_reset();
    repeat (5) begin
      predict(); tests++;
      if (act_v !== exp_v) begin fails++; $display("FAIL coll_pre cyc=%0d got=%h exp=%h", cycn, act_v, exp_v); end
      tick();
    end
    bus.redirect = 1; bus.redirect_pc = 16'h0040; bus.deq = 1;
    predict(); tests++;
    if (act_v !== exp_v) begin fails++; $display("FAIL coll_same got=%h exp=%h", act_v, exp_v); end
    tick();
    bus.redirect = 0; bus.deq = 0;
    predict(); tests++;
    if ({bus.instr_valid, bus.mem_rd, bus.mem_addr} !== {1'b0, 1'b1, 16'h0040}) begin
      fails++; $display("FAIL coll_after got=%b/%b/%h exp=0/1/0040", bus.instr_valid, bus.mem_rd, bus.mem_addr);
    end
    tick();
  endtask
  task automatic test_halt();
    logic saw = 1'b0;
    do_reset();
    halt_en = 1; halt_addr = 16'h6;
    repeat (10) begin
      predict(); tests++;
      if (act_v !== exp_v) begin fails++; $display("FAIL halt_fill cyc=%0d got=%h exp=%h", cycn, act_v, exp_v); end
      tick();
    end
    bus.deq = 1;
    repeat (6) begin
      predict(); tests++;
      saw |= bus.instr_halt;
      if (act_v !== exp_v) begin fails++; $display("FAIL halt_drain cyc=%0d got=%h exp=%h", cycn, act_v, exp_v); end
      tick();
    end
    tests++;
    if (!saw || reads.size() != 4 || bus.fetch_stall !== 1'b0 || bus.instr_valid !== 1'b0) begin
      fails++; $display("FAIL halt_stop got=%b/%0d/%b exp=1/4/0", saw, reads.size(), bus.fetch_stall);
    end
    bus.deq = 0; bus.redirect = 1; bus.redirect_pc = 16'h0020;
    predict(); tests++;
    if (act_v !== exp_v) begin fails++; $display("FAIL halt_redir got=%h exp=%h", act_v, exp_v); end
    tick();
    bus.redirect = 0;
    predict(); tests++;
    if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 16'h0020}) begin
      fails++; $display("FAIL halt_resume got=%b/%h exp=1/0020", bus.mem_rd, bus.mem_addr);
    end
    tick();
  endtask
  task automatic test_error();
    do_reset();
    err_en = 1; err_addr = 16'h4; lat_min = 2; lat_max = 2; bus.deq = 1;
    repeat (12) begin
      predict(); tests++;
      if (act_v !== exp_v) begin fails++; $display("FAIL err_run cyc=%0d got=%h exp=%h", cycn, act_v, exp_v); end
      tick();
    end
    tests++;
    if (bus.err !== 1'b1 || reads.size() != 3 || bus.instr_valid !== 1'b0) begin
      fails++; $display("FAIL err_stop got=%b/%0d exp=1/3", bus.err, reads.size());
    end
    bus.redirect = 1; bus.redirect_pc = 16'h0030;
    predict(); tests++;
    if (act_v !== exp_v) begin fails++; $display("FAIL err_redir got=%h exp=%h", act_v, exp_v); end
    tick();
    bus.redirect = 0;
    repeat (6) begin
      predict(); tests++;
      if (act_v !== exp_v) begin fails++; $display("FAIL err_resume cyc=%0d got=%h exp=%h", cycn, act_v, exp_v); end
      tick();
    end
    tests++;
    if (bus.err !== 1'b1 || reads.size() <= 3) begin
      fails++; $display("FAIL err_sticky got=%b/%0d exp=1/>3", bus.err, reads.size());
    end
    bus.deq = 0;
  endtask
  task automatic test_reset_mid();
    do_reset();
    lat_min = 4; lat_max = 4;
    repeat (2) begin
      predict(); tests++;
      if (act_v !== exp_v) begin fails++; $display("FAIL rmid_pre cyc=%0d got=%h exp=%h", cycn, act_v, exp_v); end
      tick();
    end
    rst = 1;
    predict(); tests++;
    if (act_v !== 53'h0) begin fails++; $display("FAIL rmid_zero got=%h exp=0", act_v); end
    tick();
    rst = 0; bus.redirect = 1; bus.redirect_pc = 16'h0;
    repeat (2) begin
      predict(); tests++;
      if (act_v !== exp_v) begin fails++; $display("FAIL rmid_stale cyc=%0d got=%h exp=%h", cycn, act_v, exp_v); end
      tick();
    end
    bus.redirect = 0;
    repeat (8) begin
      predict(); tests++;
      if (act_v !== exp_v) begin fails++; $display("FAIL rmid_run cyc=%0d got=%h exp=%h", cycn, act_v, exp_v); end
      tick();
    end
    tests++;
    if (bus.instr_valid !== 1'b1 || bus.pcplus !== 16'h2 || bus.instr !== mem_img[0]) begin
      fails++; $display("FAIL rmid_restart got=%b/%h/%h exp=1/0002/%h", bus.instr_valid, bus.pcplus, bus.instr, mem_img[0]);
    end
  endtask
  task automatic test_random();
    do_reset();
    lat_min = 1; lat_max = 3; halt_en = 1; halt_addr = 16'h0010;
    repeat (400) begin
      bus.deq = 1'($urandom_range(0, 1));
      bus.redirect = $urandom_range(0, 19) == 0;
      bus.redirect_pc = 16'($urandom) & 16'hFFFE;
      predict(); tests++;
      if (act_v !== exp_v) begin fails++; $display("FAIL random cyc=%0d got=%h exp=%h", cycn, act_v, exp_v); end
      tick();
    end
    bus.deq = 0; bus.redirect = 0;
  endtask
  initial begin
    for (int k = 0; k < 256; k++) mem_img[k] = 16'($urandom_range(65535, 1));
    test_reset();
    test_stream();
    test_fill();
    test_redirect_wait();
    test_collision();
    test_halt();
    test_error();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
